// File: rtl/hilo_mdu.sv
// Multi-cycle multiply/divide unit owning the architectural HI/LO registers.
// Mult/div results appear a fixed number of cycles after acceptance; busy stalls dependents.
module hilo_mdu #(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  localparam logic [2:0] OpMult  = 3'd1;
  localparam logic [2:0] OpMultu = 3'd2;
  localparam logic [2:0] OpDiv   = 3'd3;
  localparam logic [2:0] OpDivu  = 3'd4;
  localparam logic [2:0] OpMthi  = 3'd5;
  localparam logic [2:0] OpMtlo  = 3'd6;

  typedef enum logic [0:0] {StIdle, StRun} state_e;

  state_e      state_q, state_d;
  logic [31:0] cnt_q, cnt_d;
  logic [2:0]  op_q, op_d;
  logic [31:0] a_q, a_d, b_q, b_d;
  logic [31:0] hi_q, hi_d, lo_q, lo_d;

  logic [63:0] prod_s, prod_u;
  logic        div_sgn;
  logic [31:0] mag_a, mag_b, div_safe, quot, rem;
  logic [31:0] res_hi, res_lo;
  logic        res_we;

  // Result datapath works only from the operands latched at acceptance.
  always_comb begin
    prod_s   = {{32{a_q[31]}}, a_q} * {{32{b_q[31]}}, b_q};
    prod_u   = {32'd0, a_q} * {32'd0, b_q};
    div_sgn  = (op_q == OpDiv);
    mag_a    = (div_sgn && a_q[31]) ? -a_q : a_q;
    mag_b    = (div_sgn && b_q[31]) ? -b_q : b_q;
    // Keep the divider well defined on b==0; the result is discarded anyway.
    div_safe = (mag_b == 32'd0) ? 32'd1 : mag_b;
    quot     = mag_a / div_safe;
    rem      = mag_a % div_safe;
    res_hi   = hi_q;
    res_lo   = lo_q;
    res_we   = 1'b0;
    case (op_q)
      OpMult: begin
        {res_hi, res_lo} = prod_s;
        res_we           = 1'b1;
      end
      OpMultu: begin
        {res_hi, res_lo} = prod_u;
        res_we           = 1'b1;
      end
      OpDiv, OpDivu: begin
        // Magnitude division; 0x80000000 / -1 wraps back to 0x80000000 naturally.
        res_lo = (div_sgn && (a_q[31] ^ b_q[31])) ? -quot : quot;
        res_hi = (div_sgn && a_q[31]) ? -rem : rem;
        res_we = (b_q != 32'd0);
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          case (op)
            OpMult, OpMultu, OpDiv, OpDivu: begin
              state_d = StRun;
              cnt_d   = ((op == OpMult) || (op == OpMultu)) ? MULT_CYCLES : DIV_CYCLES;
              op_d    = op;
              a_d     = a;
              b_d     = b;
            end
            OpMthi:  hi_d = a;
            OpMtlo:  lo_d = a;
            default: ;
          endcase
        end
      end
      StRun: begin
        if (cnt_q == 32'd1) begin
          state_d = StIdle;
          cnt_d   = 32'd0;
          if (res_we) begin
            hi_d = res_hi;
            lo_d = res_lo;
          end
        end else begin
          cnt_d = cnt_q - 32'd1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= StIdle;
      cnt_q   <= 32'd0;
      op_q    <= 3'd0;
      a_q     <= 32'd0;
      b_q     <= 32'd0;
      hi_q    <= 32'd0;
      lo_q    <= 32'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  assign busy = (state_q == StRun);
  assign HI   = hi_q;
  assign LO   = lo_q;

endmodule

// File: tb/tb_hilo_mdu.sv
// Bench for hilo_mdu: cycle-level reference model plus directed literal checks.
module tb_hilo_mdu;

  localparam int unsigned MultN = 5;
  localparam int unsigned DivN  = 10;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [2:0]  op;
  logic [31:0] a, b;
  logic        busy;
  logic [31:0] hi, lo;

  int checks = 0;
  int errors = 0;
  bit cmp_en = 1'b0;

  hilo_mdu #(.MULT_CYCLES(MultN), .DIV_CYCLES(DivN)) dut (
    .clk   (clk),
    .reset (rst_n),
    .start (start),
    .op    (op),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .HI    (hi),
    .LO    (lo)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: a pending result with a remaining-cycle count.
  logic [31:0] m_hi = 0, m_lo = 0, m_phi = 0, m_plo = 0;
  int          m_left = 0;
  bit          m_pwe = 0;
  longint      p, da, db, q, r;

  always @(posedge clk) begin
    if (!rst_n) begin
      m_hi = 0; m_lo = 0; m_left = 0; m_pwe = 0;
    end else if (m_left > 0) begin
      m_left--;
      if (m_left == 0 && m_pwe) begin
        m_hi = m_phi;
        m_lo = m_plo;
      end
    end else if (start) begin
      case (op)
        3'd1, 3'd2: begin
          if (op == 3'd1) p = longint'($signed(a)) * longint'($signed(b));
          else            p = longint'({32'd0, a}) * longint'({32'd0, b});
          m_phi = p[63:32]; m_plo = p[31:0]; m_pwe = 1; m_left = MultN;
        end
        3'd3, 3'd4: begin
          if (op == 3'd3) begin
            da = longint'($signed(a)); db = longint'($signed(b));
          end else begin
            da = longint'({32'd0, a}); db = longint'({32'd0, b});
          end
          m_pwe = (b != 0);
          if (m_pwe) begin
            q = da / db; r = da % db;
            m_plo = q[31:0]; m_phi = r[31:0];
          end
          m_left = DivN;
        end
        3'd5: m_hi = a;
        3'd6: m_lo = a;
        default: ;
      endcase
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      check("model busy", {31'd0, busy}, {31'd0, (m_left > 0)});
      check("model HI", hi, m_hi);
      check("model LO", lo, m_lo);
    end
  end

  task automatic issue(input logic [2:0] o, input logic [31:0] va, input logic [31:0] vb);
    start = 1'b1; op = o; a = va; b = vb;
    @(negedge clk);
    start = 1'b0; op = 3'd0;
  endtask

  // Counts busy cycles seen from the negedge after acceptance; bounded.
  task automatic wait_idle(output int n);
    n = 0;
    while (busy && n < 40) begin
      n++;
      @(negedge clk);
    end
  endtask

  int n;

  initial begin
    rst_n = 1'b0; start = 1'b0; op = 3'd0; a = 32'd0; b = 32'd0;
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    cmp_en = 1'b1;
    check("reset busy", {31'd0, busy}, 32'd0);
    check("reset HI", hi, 32'd0);
    check("reset LO", lo, 32'd0);

    issue(3'd1, 32'hFFFFFFFE, 32'h3);
    wait_idle(n);
    check("mult busy cycles", n, MultN);
    check("mult HI", hi, 32'hFFFFFFFF);
    check("mult LO", lo, 32'hFFFFFFFA);

    issue(3'd2, 32'hFFFFFFFE, 32'h3);
    wait_idle(n);
    check("multu busy cycles", n, MultN);
    check("multu HI", hi, 32'h00000002);
    check("multu LO", lo, 32'hFFFFFFFA);

    issue(3'd3, 32'hFFFFFFF9, 32'h2);
    wait_idle(n);
    check("div busy cycles", n, DivN);
    check("div LO", lo, 32'hFFFFFFFD);
    check("div HI", hi, 32'hFFFFFFFF);

    issue(3'd4, 32'd7, 32'd2);
    wait_idle(n);
    check("divu LO", lo, 32'd3);
    check("divu HI", hi, 32'd1);

    issue(3'd3, 32'h80000000, 32'hFFFFFFFF);
    wait_idle(n);
    check("div ovf LO", lo, 32'h80000000);
    check("div ovf HI", hi, 32'h0);

    issue(3'd3, 32'd7, 32'hFFFFFFFE);
    wait_idle(n);
    check("div 7/-2 LO", lo, 32'hFFFFFFFD);
    check("div 7/-2 HI", hi, 32'h1);

    issue(3'd7, 32'h55555555, 32'h1);
    check("op7 busy", {31'd0, busy}, 32'd0);
    issue(3'd0, 32'h55555555, 32'h1);
    check("op0 HI", hi, 32'h1);

    issue(3'd5, 32'h12345678, 32'h0);
    issue(3'd6, 32'h9ABCDEF0, 32'h0);
    check("mthi HI", hi, 32'h12345678);
    check("mtlo LO", lo, 32'h9ABCDEF0);
    issue(3'd4, 32'd5, 32'd0);
    wait_idle(n);
    check("div0 busy cycles", n, DivN);
    check("div0 HI", hi, 32'h12345678);
    check("div0 LO", lo, 32'h9ABCDEF0);

    // Back-to-back: request held through completion must not be taken at T0+N.
    start = 1'b1; op = 3'd1; a = 32'd6; b = 32'd7;
    @(negedge clk);
    a = 32'd2; b = 32'd2;
    repeat (MultN) @(negedge clk);
    check("b2b first LO", lo, 32'd42);
    check("b2b idle at T0+N", {31'd0, busy}, 32'd0);
    @(negedge clk);
    start = 1'b0; op = 3'd0;
    wait_idle(n);
    check("b2b second LO", lo, 32'd4);

    issue(3'd1, 32'd3, 32'd5);
    @(negedge clk);
    start = 1'b1; op = 3'd6; a = 32'hDEADBEEF;
    @(negedge clk);
    start = 1'b0; op = 3'd0;
    wait_idle(n);
    check("overlap LO", lo, 32'd15);
    check("overlap HI", hi, 32'd0);

    issue(3'd5, 32'hCAFEF00D, 32'h0);
    issue(3'd3, 32'd100, 32'd7);
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("abort busy", {31'd0, busy}, 32'd0);
    check("abort HI", hi, 32'd0);
    check("abort LO", lo, 32'd0);
    repeat (DivN + 4) @(negedge clk);
    check("abort no late HI", hi, 32'd0);
    check("abort no late LO", lo, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
